// File: rtl/usr_param.sv
// usr_param: parametrised universal shift register.
//
// Shifts, rotates and arithmetic-shifts a WIDTH-bit register by a requested
// step count, one bit per clock, under a start/busy/done handshake. LOAD,
// HOLD and zero-length shifts complete in a single cycle.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   reset    - synchronous, active-high reset (overrides everything)
//   start    - operation request, sampled only while idle
//   s        - mode select (HOLD/SHR/SHL/LOAD/ROR/ROL/ASR/reserved)
//   d        - parallel load data
//   amt      - step count, saturated to WIDTH
//   ser_msb  - serial fill bit entering the MSB on SHR
//   ser_lsb  - serial fill bit entering the LSB on SHL
//   q        - register contents
//   so       - last bit shifted or rotated out
//   busy     - high while a multi-step operation is running
//   done     - one-cycle pulse when an accepted operation completes
module usr_param #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] d,
  input  logic [CW-1:0]    amt,
  input  logic             ser_msb,
  input  logic             ser_lsb,
  output logic [WIDTH-1:0] q,
  output logic             so,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // True for the modes that move bits and therefore take one cycle per step.
  function automatic logic is_shift(input logic [2:0] mode);
    logic r;
    case (mode)
      M_SHR, M_SHL, M_ROR, M_ROL, M_ASR: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  // One step of the selected mode; returns {bit_out, next_value}.
  // Non-moving modes return the current serial-out bit and value unchanged.
  function automatic logic [WIDTH:0] shift_step(
    input logic [2:0]       mode,
    input logic [WIDTH-1:0] cur,
    input logic             cur_so,
    input logic             fill_msb,
    input logic             fill_lsb
  );
    logic [WIDTH:0] r;
    case (mode)
      M_SHR:   r = {cur[0],       fill_msb,       cur[WIDTH-1:1]};
      M_SHL:   r = {cur[WIDTH-1], cur[WIDTH-2:0], fill_lsb};
      M_ROR:   r = {cur[0],       cur[0],         cur[WIDTH-1:1]};
      M_ROL:   r = {cur[WIDTH-1], cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ASR:   r = {cur[0],       cur[WIDTH-1],   cur[WIDTH-1:1]};
      default: r = {cur_so,       cur};
    endcase
    return r;
  endfunction

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [2:0]         mode_r, mode_s;
  logic [WIDTH-1:0]   q_r, q_s;
  logic               so_r, so_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [CW-1:0]      n_s;
  logic [WIDTH:0]     step_s;

  // Requested amount saturated to the register width.
  always_comb begin
    if (amt > CW'(WIDTH)) begin
      n_s = CW'(WIDTH);
    end else begin
      n_s = amt;
    end
  end

  // Next-state and next-output logic of the IDLE/SHIFT controller.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    q_s     = q_r;
    so_s    = so_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    step_s  = shift_step(mode_r, q_r, so_r, ser_msb, ser_lsb);
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (start) begin
          if (s == M_LOAD) begin
            q_s    = d;
            done_s = 1'b1;
          end else if (is_shift(s) && (n_s != {CW{1'b0}})) begin
            state_s = SHIFT;
            mode_s  = s;
            cnt_s   = n_s;
            busy_s  = 1'b1;
          end else begin
            // HOLD, reserved mode, or a zero-length shift: immediate completion.
            done_s = 1'b1;
          end
        end else begin
          done_s = 1'b0;
        end
      end
      SHIFT: begin
        so_s  = step_s[WIDTH];
        q_s   = step_s[WIDTH-1:0];
        cnt_s = cnt_r - CW'(1);
        // The step that consumes the last count finishes the operation.
        if (cnt_r <= CW'(1)) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          cnt_s   = {CW{1'b0}};
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      mode_r  <= M_HOLD;
      q_r     <= {WIDTH{1'b0}};
      so_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
      q_r     <= q_s;
      so_r    <= so_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign q    = q_r;
  assign so   = so_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_usr_param.sv
// tb_usr_param: directed self-checking bench for usr_param with WIDTH=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_usr_param;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset;
  logic             start;
  logic [2:0]       s;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    amt;
  logic             ser_msb;
  logic             ser_lsb;
  logic [WIDTH-1:0] q;
  logic             so;
  logic             busy;
  logic             done;

  int checks;
  int failures;

  usr_param #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .s       (s),
    .d       (d),
    .amt     (amt),
    .ser_msb (ser_msb),
    .ser_lsb (ser_lsb),
    .q       (q),
    .so      (so),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks q, so, busy and done together after an edge.
  task automatic check_all(input string tag, input logic [7:0] eq, input logic eso,
                           input logic ebusy, input logic edone);
    check({tag, ".q"},    {24'd0, q},     {24'd0, eq});
    check({tag, ".so"},   {31'd0, so},    {31'd0, eso});
    check({tag, ".busy"}, {31'd0, busy},  {31'd0, ebusy});
    check({tag, ".done"}, {31'd0, done},  {31'd0, edone});
  endtask

  initial begin
    int late_done;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b1;
    s        = 3'b011;
    d        = 8'hFF;
    amt      = 4'd0;
    ser_msb  = 1'b0;
    ser_lsb  = 1'b0;

    // Reset held two cycles with a LOAD request pending.
    tick();
    tick();
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check_all("idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // LOAD 00011101.
    start = 1'b1; s = 3'b011; d = 8'b0001_1101;
    tick();
    check_all("load", 8'h1D, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    check_all("load_after", 8'h1D, 1'b0, 1'b0, 1'b0);

    // ROR by 3.
    start = 1'b1; s = 3'b100; amt = 4'd3;
    tick();
    check_all("ror_acc", 8'h1D, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    check_all("ror_s1", 8'h8E, 1'b1, 1'b1, 1'b0);
    tick();
    check_all("ror_s2", 8'h47, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("ror_s3", 8'hA3, 1'b1, 1'b0, 1'b1);
    tick();
    check_all("ror_end", 8'hA3, 1'b1, 1'b0, 1'b0);

    // SHL by 2 with ser_lsb=1, plus an ignored LOAD request while busy.
    start = 1'b1; s = 3'b010; amt = 4'd2; ser_lsb = 1'b1;
    tick();
    check_all("shl_acc", 8'hA3, 1'b1, 1'b1, 1'b0);
    s = 3'b011; d = 8'h00;
    tick();
    check_all("shl_s1", 8'h47, 1'b1, 1'b1, 1'b0);
    tick();
    check_all("shl_s2", 8'h8F, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    check_all("shl_end", 8'h8F, 1'b0, 1'b0, 1'b0);

    // ASR with amt=12 saturating to 8 steps.
    start = 1'b1; s = 3'b110; amt = 4'd12; ser_lsb = 1'b0;
    tick();
    check_all("asr_acc", 8'h8F, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("asr_busy", {31'd0, busy}, {31'd0, (i < 8)});
      check("asr_done", {31'd0, done}, {31'd0, (i == 8)});
    end
    check_all("asr_final", 8'hFF, 1'b1, 1'b0, 1'b1);

    // SHR with amt=0 completes immediately; back-to-back with the ASR done.
    start = 1'b1; s = 3'b001; amt = 4'd0;
    tick();
    check_all("shr0", 8'hFF, 1'b1, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    check_all("shr0_after", 8'hFF, 1'b1, 1'b0, 1'b0);

    // Reserved mode behaves as HOLD.
    start = 1'b1; s = 3'b111; amt = 4'd5;
    tick();
    check_all("rsvd", 8'hFF, 1'b1, 1'b0, 1'b1);
    start = 1'b0;

    // Reset in the middle of ROL by 8 from A5.
    start = 1'b1; s = 3'b011; d = 8'hA5;
    tick();
    check_all("load_a5", 8'hA5, 1'b1, 1'b0, 1'b1);
    s = 3'b101; amt = 4'd8;
    tick();
    check_all("rol_acc", 8'hA5, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    check_all("rol_s1", 8'h4B, 1'b1, 1'b1, 1'b0);
    tick();
    check_all("rol_s2", 8'h96, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("rol_s3", 8'h2D, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    late_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) late_done++;
    end
    check("no_late_done", late_done, 0);

    // Fresh LOAD after the abort.
    start = 1'b1; s = 3'b011; d = 8'h3C;
    tick();
    check_all("load_3c", 8'h3C, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    check_all("load_3c_after", 8'h3C, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usr_param.md
Name: usr_param

Overview:
Parametrised universal shift register, the successor to the fixed 8-bit usr. It supports configurable WIDTH, rotate and arithmetic-shift modes, and multi-bit shifts by a requested amount. A shift runs one bit per clock under a start/busy/done handshake, with serial in/out on both ends. It is intended as a reusable datapath shifter and serialiser.

Parameters:
WIDTH, 8, register width in bits (>=2)
CW, $clog2(WIDTH+1), width of shift-amount port (derived; do not override)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request operation; sampled only in IDLE
s  input  3  mode select, sampled with start
d  input  WIDTH  parallel load data, sampled with start
amt  input  CW  shift/rotate step count, sampled with start
ser_msb  input  1  serial fill bit entering MSB on SHR
ser_lsb  input  1  serial fill bit entering LSB on SHL
q  output  WIDTH  register contents
so  output  1  last bit shifted/rotated out (registered)
busy  output  1  high while a multi-step operation is in progress
done  output  1  one-cycle pulse when an accepted operation completes

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-operation): q=0, so=0, busy=0, done=0, FSM=IDLE, internal count=0.
- Modes (s): 000 HOLD; 001 SHR logical, q<={ser_msb,q[W-1:1]}; 010 SHL logical, q<={q[W-2:0],ser_lsb}; 011 LOAD q<=d; 100 ROR; 101 ROL; 110 ASR, MSB replicated; 111 reserved, treated as HOLD.
- so per step: the bit leaving the register (q[0] for SHR/ROR/ASR, q[W-1] for SHL/ROL). so holds its value between steps and is not changed by LOAD/HOLD.
- Amount: effective count n = min(amt, WIDTH). Values above WIDTH saturate.
- FSM states: IDLE, SHIFT.
- IDLE, start=0: q holds, busy=0, done=0.
- IDLE, start=1 with LOAD: q<=d at that edge; done=1 during the following cycle; busy stays 0.
- IDLE, start=1 with HOLD/reserved, or a shift mode with n=0: q unchanged; done=1 the next cycle; busy stays 0.
- IDLE, start=1 with a shift mode and n>0: latch mode and n; go to SHIFT; busy=1 from the next cycle.
- SHIFT: one step per edge. ser_msb/ser_lsb are sampled live at each step edge. count decrements each step.
- On the edge performing step n: return to IDLE, busy<=0, done<=1 for exactly one cycle.
- Latency: start at edge k, steps at edges k+1..k+n, busy high n cycles, done high in the cycle after edge k+n.
- start while busy=1 is ignored: no queuing, and mode/amt/d changes have no effect.
- start in the same cycle done=1 (FSM in IDLE) is accepted normally, giving back-to-back operation.
- ROR/ROL with n=WIDTH restore the original value. ASR with n=WIDTH yields all copies of the original MSB.
- No X propagation: all registers are reset, and the reserved mode is defined.

Test Plan:
(WIDTH=8 throughout)
- Reset: assert reset 2 cycles with start=1, s=011, d=8'hFF -> q=0, busy=0, done=0, so=0.
- LOAD: start=1, s=011, d=8'b00011101 one cycle -> q=8'b00011101 after that edge, done=1 for one cycle, busy never 1.
- ROR amt=3 from 00011101 -> busy=1 for 3 cycles, q=10001110, 01000111, 10100011, done pulse as busy falls, so=1.
- SHL amt=2, ser_lsb=1 from 10100011 -> q=01000111 then 10001111, so=0; while busy, assert start with s=011, d=0 -> ignored, q still 10001111.
- ASR amt=12 (saturates to 8) from 10001111 -> busy exactly 8 cycles, final q=8'hFF. Then SHR amt=0 -> q unchanged, done next cycle, busy=0.
- Reset mid-op: ROL amt=8 from 8'hA5, assert reset after 3 steps -> next edge q=0, busy=0, done=0, no later done pulse. A fresh LOAD then works normally.
